// File: rtl/posit_to_fp_pipe.sv
// posit_to_fp_pipe
// Three-stage posit -> IEEE-754 converter with a valid/ready handshake.
//   Stage 1: sign, magnitude (two's complement), zero and NaR detect.
//   Stage 2: regime run length, exponent/fraction extraction, signed scale.
//   Stage 3: biased exponent, rounding, overflow/underflow and special packing.
//
// Parameters
//   FPWID : posit and IEEE word width (16, 32 or 64)
//   es    : posit exponent field width
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_valid/i_ready/i   : posit operand handshake
//   o_valid/o_ready/o   : IEEE result handshake
//   o_inexact           : rounding discarded nonzero bits (also set on ovf/unf)
//   o_ovf               : result saturated to signed infinity
//   o_unf               : result flushed to signed zero (no denormals)
//
// Build option
//   POSIT2FP_RNE_EN : when defined, round to nearest even; otherwise truncate.
module posit_to_fp_pipe #(
  parameter int FPWID = 32,
  parameter int es    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [FPWID-1:0] i,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [FPWID-1:0] o,
  output logic             o_inexact,
  output logic             o_ovf,
  output logic             o_unf
);

  localparam int N    = FPWID;
  localparam int EMSB = (FPWID == 16) ? 4 : (FPWID == 64) ? 10 : 7;
  localparam int FMSB = FPWID - EMSB - 3;
  localparam int BIAS = (1 << EMSB) - 1;
  localparam int EMAX = (1 << (EMSB + 1)) - 1;
  localparam int FW   = N - es;          // fraction bits left after regime/exponent
  localparam int GB   = FW - FMSB - 2;   // guard bit position inside the fraction
  localparam int KW   = $clog2(N) + 1;
  localparam int SW   = EMSB + 3;
  localparam int XW   = EMSB + 4;

  // ---------------------------------------------------------------- handshake
  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  // Ready ripples back combinationally so a full pipe that drains also accepts.
  assign ld3     = ~v3 | o_ready;
  assign ld2     = ~v2 | ld3;
  assign ld1     = ~v1 | ld2;
  assign i_ready = ld1;
  assign o_valid = v3;

  // ---------------------------------------------------------------- stage 1
  logic         sgn1, zero1, nar1;
  logic [N-1:0] abs1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      sgn1  <= 1'b0;
      zero1 <= 1'b0;
      nar1  <= 1'b0;
      abs1  <= '0;
    end else if (ld1) begin
      v1 <= i_valid;
      if (i_valid) begin
        sgn1  <= i[N-1];
        abs1  <= i[N-1] ? -i : i;
        zero1 <= (i == '0);
        nar1  <= (i == {1'b1, {(N-1){1'b0}}});
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [KW-1:0] k_cnt;
  logic          run_on;
  logic [KW:0]   sh_amt;
  logic [N-1:0]  shifted;
  logic [es-1:0] e_val;
  logic [SW-1:0] k_ext, r_val, scale_c;

  always_comb begin
    k_cnt  = '0;
    run_on = 1'b1;
    for (int b = N - 2; b >= 0; b--) begin
      if (run_on && (abs1[b] == abs1[N-2])) k_cnt = k_cnt + KW'(1);
      else                                  run_on = 1'b0;
    end
    // A run that reaches bit 0 has no terminating bit to skip.
    sh_amt  = (k_cnt == KW'(N - 1)) ? (KW+1)'(N) : (KW+1)'(k_cnt) + (KW+1)'(2);
    shifted = abs1 << sh_amt;
    e_val   = shifted[N-1 -: es];
    k_ext   = SW'(k_cnt);
    r_val   = abs1[N-2] ? (k_ext - SW'(1)) : (SW'(0) - k_ext);
    scale_c = (r_val << es) + SW'(e_val);
  end

  logic          sgn2, zero2, nar2;
  logic [SW-1:0] scale2;
  logic [FW-1:0] frac2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      sgn2   <= 1'b0;
      zero2  <= 1'b0;
      nar2   <= 1'b0;
      scale2 <= '0;
      frac2  <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        sgn2   <= sgn1;
        zero2  <= zero1;
        nar2   <= nar1;
        scale2 <= scale_c;
        frac2  <= shifted[FW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [FMSB:0] mant, mant_r;
  logic          guard, sticky, inc, carry;
  logic [XW-1:0] x_val;
  logic          ovf_c, unf_c;
  logic [N-1:0]  o_c;
  logic          inx_f, ovf_f, unf_f;

  always_comb begin
    mant   = frac2[FW-1 -: FMSB+1];
    guard  = frac2[GB];
    sticky = |frac2[GB-1:0];
`ifdef POSIT2FP_RNE_EN
    inc = guard & (sticky | mant[0]);
`else
    inc = 1'b0;
`endif
    {carry, mant_r} = {1'b0, mant} + (FMSB+2)'(inc);
    // A mantissa carry leaves mant_r at zero, which is exactly 2.0 -> bump exponent.
    x_val = {scale2[SW-1], scale2} + XW'(BIAS) + XW'(carry);
    ovf_c = ~x_val[XW-1] & (x_val >= XW'(EMAX));
    unf_c = x_val[XW-1] | (x_val == '0);

    o_c   = '0;
    inx_f = 1'b0;
    ovf_f = 1'b0;
    unf_f = 1'b0;
    if (!zero2) begin
      if (nar2) begin
        o_c = {1'b0, {(EMSB+1){1'b1}}, 1'b1, {FMSB{1'b0}}};
      end else if (ovf_c) begin
        o_c   = {sgn2, {(EMSB+1){1'b1}}, {(FMSB+1){1'b0}}};
        ovf_f = 1'b1;
        inx_f = 1'b1;
      end else if (unf_c) begin
        o_c   = {sgn2, {(N-1){1'b0}}};
        unf_f = 1'b1;
        inx_f = 1'b1;
      end else begin
        o_c   = {sgn2, x_val[EMSB:0], mant_r};
        inx_f = guard | sticky;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3        <= 1'b0;
      o         <= '0;
      o_inexact <= 1'b0;
      o_ovf     <= 1'b0;
      o_unf     <= 1'b0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        o         <= o_c;
        o_inexact <= inx_f;
        o_ovf     <= ovf_f;
        o_unf     <= unf_f;
      end
    end
  end

endmodule

// File: tb/tb_posit_to_fp_pipe.sv
module tb_posit_to_fp_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_valid, i_ready, o_valid, o_ready, o_inexact, o_ovf, o_unf;
  logic [31:0] i, o;
  logic        h_i_valid, h_i_ready, h_o_valid, h_o_ready, h_o_inexact, h_o_ovf, h_o_unf;
  logic [15:0] h_i, h_o;

  posit_to_fp_pipe #(.FPWID(32), .es(2)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i(i),
    .o_valid(o_valid), .o_ready(o_ready), .o(o),
    .o_inexact(o_inexact), .o_ovf(o_ovf), .o_unf(o_unf)
  );

  posit_to_fp_pipe #(.FPWID(16), .es(1)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(h_i_valid), .i_ready(h_i_ready), .i(h_i),
    .o_valid(h_o_valid), .o_ready(h_o_ready), .o(h_o),
    .o_inexact(h_o_inexact), .o_ovf(h_o_ovf), .o_unf(h_o_unf)
  );

`ifdef POSIT2FP_RNE_EN
  localparam logic [31:0] RND_EXP = 32'h3F800002;
`else
  localparam logic [31:0] RND_EXP = 32'h3F800001;
`endif

  typedef struct {
    logic [31:0] o;
    logic [2:0]  flg;   // {inexact, ovf, unf}
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   acc_cnt  = 0;

  logic [31:0] bp_in  [8] = '{32'h40000000, 32'h48000000, 32'hC0000000, 32'h50000000,
                              32'h60000000, 32'h30000000, 32'h44000000, 32'h00000001};
  logic [31:0] bp_exp [8] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h40800000,
                              32'h41800000, 32'h3E800000, 32'h3FC00000, 32'h03800000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send32(input logic [31:0] v, input logic [31:0] ev, input logic [2:0] ef,
                        input bit lat);
    bit done = 1'b0;
    i_valid = 1'b1;
    i       = v;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (i_ready) begin
        q32.push_back('{ev, ef, cyc, lat});
        acc_cnt++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk("send32_accept", done, 1);
    i_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] v, input logic [15:0] ev, input logic [2:0] ef);
    bit done = 1'b0;
    h_i_valid = 1'b1;
    h_i       = v;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (h_i_ready) begin
        q16.push_back('{{16'h0, ev}, ef, cyc, 1'b1});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk("send16_accept", done, 1);
    h_i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60; t++) begin
      if (q32.size() == 0 && q16.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_pending", q32.size() + q16.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_valid && o_ready) begin
      if (q32.size() == 0) chk("o32_unexpected", q32.size(), 1);
      else begin
        e = q32.pop_front();
        chk("o32_data", o, e.o);
        chk("o32_flags", {o_inexact, o_ovf, o_unf}, e.flg);
        if (e.lat) chk("o32_latency", cyc - e.acc, 3);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && h_o_valid && h_o_ready) begin
      if (q16.size() == 0) chk("o16_unexpected", q16.size(), 1);
      else begin
        e = q16.pop_front();
        chk("o16_data", h_o, e.o[15:0]);
        chk("o16_flags", {h_o_inexact, h_o_ovf, h_o_unf}, e.flg);
        chk("o16_latency", cyc - e.acc, 3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i         = '0;
    o_ready   = 1'b1;
    h_i_valid = 1'b0;
    h_i       = '0;
    h_o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o", o, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_flags", {o_inexact, o_ovf, o_unf}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_i_ready", i_ready, 1);

    // basic values, specials, boundaries and rounding, streamed back to back
    send32(32'h40000000, 32'h3F800000, 3'b000, 1'b1);
    send32(32'hC0000000, 32'hBF800000, 3'b000, 1'b1);
    send32(32'h48000000, 32'h40000000, 3'b000, 1'b1);
    send32(32'h00000000, 32'h00000000, 3'b000, 1'b1);
    send32(32'h80000000, 32'h7FC00000, 3'b000, 1'b1);
    send32(32'h7FFFFFFF, 32'h7B800000, 3'b000, 1'b1);
    send32(32'h80000001, 32'hFB800000, 3'b000, 1'b1);
    send32(32'h00000001, 32'h03800000, 3'b000, 1'b1);
    send32(32'h40000008, 32'h3F800000, 3'b100, 1'b1);
    send32(32'h40000018, RND_EXP,      3'b100, 1'b1);
    send32(32'h44000000, 32'h3FC00000, 3'b000, 1'b1);

    send16(16'h7FFF, 16'h7C00, 3'b110);
    send16(16'h0001, 16'h0000, 3'b101);
    drain();

    // backpressure: consumer stalls for 5 cycles while 8 values are offered
    o_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int n = 0; n < 8; n++) send32(bp_in[n], bp_exp[n], 3'b000, 1'b0);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (o_valid && q32.size() > 0) chk("stall_hold", o, q32[0].o);
        end
        chk("bp_accepts", acc_cnt, 3);
        chk("bp_i_ready", i_ready, 0);
        chk("bp_o_valid", o_valid, 1);
        @(posedge clk);
        #1;
        o_ready = 1'b1;
      end
    join
    drain();

    // reset with three items in flight
    o_ready = 1'b0;
    send32(32'h40000000, 32'h3F800000, 3'b000, 1'b0);
    send32(32'h48000000, 32'h40000000, 3'b000, 1'b0);
    send32(32'hC0000000, 32'hBF800000, 3'b000, 1'b0);
    chk("pre_rst_o_valid", o_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o", o, 0);
    chk("mid_rst_o_valid", o_valid, 0);
    chk("mid_rst_flags", {o_inexact, o_ovf, o_unf}, 0);
    q32.delete();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    o_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("post_rst_no_stale", o_valid, 0);
    end
    chk("post_rst_i_ready", i_ready, 1);
    @(posedge clk);
    #1;
    send32(32'h48000000, 32'h40000000, 3'b000, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/posit_to_fp_pipe.md
# posit_to_fp_pipe

Pipelined posit-to-IEEE-754 converter: the inverse of the floating point to posit path in the posit arithmetic unit. Accepts one `FPWID`-bit posit (exponent size `es`) per cycle over a valid/ready handshake. Decodes sign, regime, exponent and fraction, rounds to the IEEE format defined by the `fp` package (`EMSB`, `FMSB`, bias `{1'b0,{EMSB{1'b1}}}`), and returns the result three stages later with exception flags. Full-rate under no backpressure; stalls cleanly when the consumer deasserts ready.

## Interface
- `FPWID`, 32, posit and IEEE word width; supported: 16, 32, 64.
- `es`, 2, posit exponent field width; taken from the `posit` package.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  input posit valid.
- `i_ready`  out  1  converter can accept `i` this cycle.
- `i`  in  FPWID  posit operand.
- `o_valid`  out  1  result valid.
- `o_ready`  in  1  consumer accepts `o` this cycle.
- `o`  out  FPWID  IEEE-754 result.
- `o_inexact`  out  1  rounding discarded nonzero bits.
- `o_ovf`  out  1  magnitude exceeded the largest finite IEEE value; `o` = ±Inf.
- `o_unf`  out  1  magnitude below the smallest normal; `o` = signed zero.

## Operation
- Stage 1 (decode)
  - Register `sgn = i[N-1]`, `abs = sgn ? -i : i`, zero flag (`i==0`) and NaR flag (`i=={1,0..0}`).
- Stage 2 (regime/extract)
  - Compute regime run length `k` of bits `abs[N-2:0]` equal to `abs[N-2]` via a leading-zero/one count.
  - Regime value `R = abs[N-2] ? k-1 : -k`.
  - Shift `abs` left by `k+2` (`k+1` when the run reaches bit 0).
  - Top `es` bits are the exponent, zero-filled if truncated; the remaining bits form the fraction with an implicit leading 1.
  - Register the signed scale `S = R*2^es + e`, E+2 bits wide, plus the fraction.
- Stage 3 (round/pack)
  - Biased exponent `X = S + BIAS`.
  - Truncate the fraction to `FMSB+1` bits; guard = next bit, sticky = OR of the rest.
  - Rounding per Configuration.
  - A mantissa carry-out increments `X`.
  - `X >= 2^(EMSB+1)-1`: `o` = {sgn, all-ones exp, 0}, `o_ovf`=1.
  - `X <= 0`: `o` = {sgn, 0}, `o_unf`=1. Flush to zero; no denormals.
  - Zero input: `o`=0, flags 0.
  - NaR input: `o` = {0, all-ones exp, 1, 0…} (quiet NaN), flags 0.
  - `o_inexact` = guard|sticky for finite nonzero results, and 1 on ovf/unf.

## Timing
- Latency: 3 cycles from an accepted input (`i_valid & i_ready`) to `o_valid`. Throughput: 1 per cycle.
- Each stage holds a valid bit `v1..v3`.
  - Stage n loads when `~vn | adv(n+1)`, with `adv4 = o_ready`.
  - `i_ready = ~v1 | adv2`. This is a combinational ready chain; no bubbles are inserted.
- `o_valid = v3`.
  - `o` and the flags are stable while `o_valid & ~o_ready`.
  - Data registers update only when their stage loads.
- Simultaneous accept and drain on a full pipe: all stages advance; no loss, no duplication.
- Reset (any time, including mid-stream): `v1..v3`=0, `o`=0, all flags 0, `i_ready`=1 after release. In-flight items are discarded.
- `i` is ignored when `i_valid`=0. A stage loads a bubble (`vn`=0) when the upstream stage is invalid.

## Configuration
- `POSIT2FP_RNE_EN` defined: round-to-nearest-even.
  - Increment when guard & (sticky | lsb).
- Undefined: truncate toward zero; no increment.
  - `o_inexact` is still reported.
  - Overflow remains possible only from scale, not from rounding carry.

## Test plan
- FPWID=32, es=2, `o_ready`=1:
  - `0x40000000` -> `0x3F800000`.
  - `0xC0000000` -> `0xBF800000`.
  - `0x48000000` -> `0x40000000`.
  - All three with `o_inexact`=0, each appearing 3 cycles after accept.
- Specials:
  - `0x00000000` -> `0x00000000`.
  - `0x80000000` -> `0x7FC00000`.
  - `0x7FFFFFFF` (maxpos, 2^120) -> `0x7B800000`, flags 0.
- Rounding:
  - `0x40000008` -> `0x3F800000`, inexact=1 (tie to even).
  - `0x40000018` -> `0x3F800002` with `POSIT2FP_RNE_EN`, `0x3F800001` without; inexact=1 in both builds.
- FPWID=16, es=1, `0x7FFF` (2^28) -> `0x7C00` with `o_ovf`=1. `0x0001` (2^-28) -> `0x0000` with `o_unf`=1.
- Backpressure:
  - Stream 8 back-to-back values while holding `o_ready`=0 for 5 cycles.
  - `i_ready` drops after 3 accepts.
  - `o` is held steady while stalled.
  - All 8 outputs emerge in order with none dropped or duplicated.
- Reset: assert `rst_n`=0 with 3 items in flight.
  - Outputs go to 0 immediately; `o_valid`=0.
  - No stale item appears after release.
  - The first new input converts correctly 3 cycles later.
